// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter slice.
//
// Contents:
//   arb_state_e   - arbiter FSM states (IDLE, ISSUE, WAIT_RESP, RESP)
//   PORT0/PORT1   - upstream port indices (instruction cache, data cache)
//   *_off()       - bit offsets of each field inside a packed request-buffer
//                   entry laid out as {addr, wdata, we, be}, LSB first = be
//   buf_width()   - total width of one packed request-buffer entry
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int BE_OFF = 0;

    function automatic int we_off(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int wdata_off(input int data_w);
        return (data_w / 8) + 1;
    endfunction

    function automatic int addr_off(input int data_w);
        return (data_w / 8) + 1 + data_w;
    endfunction

    function automatic int buf_width(input int addr_w, input int data_w);
        return addr_off(data_w) + addr_w;
    endfunction

endpackage

// File: rtl/mem_req_buffer.sv
// One-entry capture buffer for a single upstream cache port.
//
// A one-cycle request pulse is stored whenever the buffer is empty; the
// arbiter empties it again once the matching response is returned.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   req               - request pulse from the cache
//   addr/wdata/we/be  - request fields captured together with req
//   clear             - arbiter finished with the stored request
//   valid             - buffer holds a request
//   gnt               - buffer empty, a request this cycle will be captured
//   buf_*             - stored request fields
module mem_req_buffer
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clear,
    output logic                valid,
    output logic                gnt,
    output logic [ADDR_W-1:0]   buf_addr,
    output logic [DATA_W-1:0]   buf_wdata,
    output logic                buf_we,
    output logic [DATA_W/8-1:0] buf_be
);

    localparam int BE_W    = DATA_W / 8;
    localparam int WE_O    = we_off(DATA_W);
    localparam int WDATA_O = wdata_off(DATA_W);
    localparam int ADDR_O  = addr_off(DATA_W);
    localparam int BUF_W   = buf_width(ADDR_W, DATA_W);

    logic [BUF_W-1:0] entry;

    // Clear can only arrive while the buffer is full, when gnt is low, so it
    // never competes with a capture in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (req && !valid) begin
            valid <= 1'b1;
            entry <= {addr, wdata, we, be};
        end
    end

    assign gnt       = ~valid;
    assign buf_be    = entry[BE_OFF +: BE_W];
    assign buf_we    = entry[WE_O];
    assign buf_wdata = entry[WDATA_O +: DATA_W];
    assign buf_addr  = entry[ADDR_O +: ADDR_W];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the instruction- and data-cache memory ports onto one memory bus.
//
// Each cache port owns a one-entry request buffer. A round-robin arbiter
// picks a buffered request, presents it on the bus, waits for the response
// (or a timeout) and returns it to the originating port. Only one memory
// transaction is outstanding at a time.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   mN_addr_i/wdata_i/we_i/be_i- request fields from cache port N
//   mN_req_i                   - request pulse, captured when mN_gnt_o=1
//   mN_gnt_o                   - port N buffer empty
//   mN_rdata_o/rvalid_o/error_o- registered response to port N
//   mem_addr_o/wdata_o/we_o/be_o - registered request fields to memory
//   mem_req_o                  - request, held until mem_gnt_i
//   mem_gnt_i                  - memory accepted the request
//   mem_rdata_i/rvalid_i/error_i - memory response
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic                m0_req_i,
    output logic                m0_gnt_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_rvalid_o,
    output logic                m0_error_o,

    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic                m1_req_i,
    output logic                m1_gnt_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_rvalid_o,
    output logic                m1_error_o,

    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic                mem_req_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic                mem_error_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

    arb_state_e          state;
    arb_state_e          state_next;
    logic                last_grant;
    logic                sel;
    logic                issue_sel;
    logic                issue_load;
    logic                resp_take;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_error;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;

    logic                b0_valid;
    logic                b0_gnt;
    logic [ADDR_W-1:0]   b0_addr;
    logic [DATA_W-1:0]   b0_wdata;
    logic                b0_we;
    logic [BE_W-1:0]     b0_be;
    logic                b0_clear;

    logic                b1_valid;
    logic                b1_gnt;
    logic [ADDR_W-1:0]   b1_addr;
    logic [DATA_W-1:0]   b1_wdata;
    logic                b1_we;
    logic [BE_W-1:0]     b1_be;
    logic                b1_clear;

    // The in-flight port's buffer is released on the edge that enters RESP,
    // so that port can accept its next request during the RESP cycle.
    assign b0_clear = resp_take && (sel == PORT0);
    assign b1_clear = resp_take && (sel == PORT1);

    mem_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .req       (m0_req_i),
        .addr      (m0_addr_i),
        .wdata     (m0_wdata_i),
        .we        (m0_we_i),
        .be        (m0_be_i),
        .clear     (b0_clear),
        .valid     (b0_valid),
        .gnt       (b0_gnt),
        .buf_addr  (b0_addr),
        .buf_wdata (b0_wdata),
        .buf_we    (b0_we),
        .buf_be    (b0_be)
    );

    mem_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .req       (m1_req_i),
        .addr      (m1_addr_i),
        .wdata     (m1_wdata_i),
        .we        (m1_we_i),
        .be        (m1_be_i),
        .clear     (b1_clear),
        .valid     (b1_valid),
        .gnt       (b1_gnt),
        .buf_addr  (b1_addr),
        .buf_wdata (b1_wdata),
        .buf_we    (b1_we),
        .buf_be    (b1_be)
    );

    assign m0_gnt_o = b0_gnt;
    assign m1_gnt_o = b1_gnt;

    // Next-state logic. A response is taken either in WAIT_RESP, or in ISSUE
    // when the memory answers in the same cycle it grants. A timeout produces
    // an error response carrying zero data.
    always_comb begin
        state_next = state;
        issue_load = 1'b0;
        issue_sel  = PORT0;
        resp_take  = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        cnt_next   = cnt;

        case (state)
            IDLE: begin
                if (b0_valid || b1_valid) begin
                    issue_load = 1'b1;
                    state_next = ISSUE;
                    if (b0_valid && b1_valid) begin
                        issue_sel = ~last_grant;
                    end else if (b1_valid) begin
                        issue_sel = PORT1;
                    end else begin
                        issue_sel = PORT0;
                    end
                end
            end

            ISSUE: begin
                if (mem_gnt_i) begin
                    cnt_next = '0;
                    if (mem_rvalid_i) begin
                        resp_take  = 1'b1;
                        resp_rdata = mem_rdata_i;
                        resp_error = mem_error_i;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT_RESP;
                    end
                end
            end

            WAIT_RESP: begin
                cnt_next = cnt + CNT_W'(1);
                if (mem_rvalid_i) begin
                    resp_take  = 1'b1;
                    resp_rdata = mem_rdata_i;
                    resp_error = mem_error_i;
                    state_next = RESP;
                end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                    resp_take  = 1'b1;
                    resp_rdata = '0;
                    resp_error = 1'b1;
                    state_next = RESP;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, arbitration history and the registered memory request. The
    // round-robin pointer only moves when both ports contended, so a lone
    // requester does not steal the next tie from the other port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= PORT1;
            sel         <= PORT0;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (issue_load) begin
                sel         <= issue_sel;
                mem_req_o   <= 1'b1;
                mem_addr_o  <= issue_sel ? b1_addr  : b0_addr;
                mem_wdata_o <= issue_sel ? b1_wdata : b0_wdata;
                mem_we_o    <= issue_sel ? b1_we    : b0_we;
                mem_be_o    <= issue_sel ? b1_be    : b0_be;
                if (b0_valid && b1_valid) begin
                    last_grant <= issue_sel;
                end
            end else if ((state == ISSUE) && mem_gnt_i) begin
                mem_req_o <= 1'b0;
            end
        end
    end

    // Response registers. Data and error are only updated for the port that
    // owns the response, so the other port keeps its last returned value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rvalid_o <= 1'b0;
            m0_error_o  <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rvalid_o <= 1'b0;
            m1_error_o  <= 1'b0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= resp_take && (sel == PORT0);
            m1_rvalid_o <= resp_take && (sel == PORT1);
            if (resp_take && (sel == PORT0)) begin
                m0_rdata_o <= resp_rdata;
                m0_error_o <= resp_error;
            end
            if (resp_take && (sel == PORT1)) begin
                m1_rdata_o <= resp_rdata;
                m1_error_o <= resp_error;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected memory
// requests and expected port responses; independent monitors compare them
// against what the DUT presents.
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        reset;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic        m0_error_o, m1_error_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_req_o;
    logic [31:0] mem_rdata_i;
    logic        mem_gnt_i, mem_rvalid_i, mem_error_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } mreq_t;

    resp_t       rq0[$];
    resp_t       rq1[$];
    mreq_t       mq[$];
    logic [32:0] model_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_gnt_wait = 0;
    int mem_resp_wait = 1;
    bit mem_silent = 1'b0;
    bit inject_late = 1'b0;

    mem_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_addr_i    (m0_addr_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_we_i      (m0_we_i),
        .m0_be_i      (m0_be_i),
        .m0_req_i     (m0_req_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_error_o   (m0_error_o),
        .m1_addr_i    (m1_addr_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_we_i      (m1_we_i),
        .m1_be_i      (m1_be_i),
        .m1_req_i     (m1_req_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_error_o   (m1_error_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_req_o    (mem_req_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_error_i  (mem_error_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic [3:0] be, input logic [31:0] rsp_data,
                                 input logic rsp_err, input int lat, input bit mem_answers,
                                 input bit expect_resp);
        mreq_t m;
        resp_t r;
        m.addr  = addr;
        m.wdata = wdata;
        m.we    = we;
        m.be    = be;
        mq.push_back(m);
        if (mem_answers) model_q.push_back({rsp_err, rsp_data});
        if (expect_resp) begin
            r.data = rsp_data;
            r.err  = rsp_err;
            r.lat  = lat;
            r.t0   = cyc;
            if (port == 0) rq0.push_back(r);
            else           rq1.push_back(r);
        end
        if (port == 0) begin
            m0_addr_i = addr; m0_wdata_i = wdata; m0_we_i = we; m0_be_i = be; m0_req_i = 1'b1;
        end else begin
            m1_addr_i = addr; m1_wdata_i = wdata; m1_we_i = we; m1_be_i = be; m1_req_i = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || mq.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rq0.size() != 0 || rq1.size() != 0 || mq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: outstanding rq0=%0d rq1=%0d mq=%0d required all 0",
                     rq0.size(), rq1.size(), mq.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResp(input int port, input logic [31:0] rdata, input logic err);
        resp_t e;
        if ((port == 0 && rq0.size() == 0) || (port == 1 && rq1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid m%0d: actual=1 required=0 (cycle %0d)", port, cyc);
        end else begin
            if (port == 0) e = rq0.pop_front();
            else           e = rq1.pop_front();
            checkOutput($sformatf("m%0d_rdata", port), 64'(rdata), 64'(e.data));
            checkOutput($sformatf("m%0d_error", port), 64'(err), 64'(e.err));
            if (e.lat >= 0) checkOutput($sformatf("m%0d_latency", port), 64'(cyc - e.t0), 64'(e.lat));
        end
    endtask

    // Response monitor: compares every port strobe with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m0_rvalid_o) checkResp(0, m0_rdata_o, m0_error_o);
                if (m1_rvalid_o) checkResp(1, m1_rdata_o, m1_error_o);
            end
        end
    end

    // Memory-side monitor: every cycle mem_req_o is high the fields must match
    // the oldest expected request; the grant retires it.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && mem_req_o) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mem_req: actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    checkOutput("mem_addr", 64'(mem_addr_o), 64'(mq[0].addr));
                    checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(mq[0].wdata));
                    checkOutput("mem_we_be", 64'({mem_we_o, mem_be_o}), 64'({mq[0].we, mq[0].be}));
                    if (mem_gnt_i) mq.delete(0);
                end
            end
        end
    end

    // Memory model: grants after mem_gnt_wait stalled cycles and answers
    // mem_resp_wait cycles after the grant, unless told to stay silent.
    initial begin
        int gnt_count = 0;
        int resp_count = 0;
        bit resp_pending = 1'b0;
        logic [32:0] rsp;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_error_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_error_i = 1'b0;
            if (reset) begin
                resp_pending = 1'b0;
                gnt_count = 0;
            end else begin
                if (inject_late) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 32'h0BAD_F00D;
                    inject_late  = 1'b0;
                end
                if (resp_pending) begin
                    resp_count++;
                    if (resp_count >= mem_resp_wait) begin
                        resp_pending = 1'b0;
                        if (model_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL model_data: response requested with empty data queue");
                        end else begin
                            rsp = model_q.pop_front();
                            mem_rvalid_i = 1'b1;
                            mem_error_i  = rsp[32];
                            mem_rdata_i  = rsp[31:0];
                        end
                    end
                end
                if (mem_req_o) begin
                    if (gnt_count >= mem_gnt_wait) begin
                        mem_gnt_i = 1'b1;
                        gnt_count = 0;
                        if (!mem_silent) begin
                            resp_pending = 1'b1;
                            resp_count = 0;
                        end
                    end else begin
                        gnt_count++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        m0_addr_i = '0; m0_wdata_i = '0; m0_we_i = 1'b0; m0_be_i = '0; m0_req_i = 1'b0;
        m1_addr_i = '0; m1_wdata_i = '0; m1_we_i = 1'b0; m1_be_i = '0; m1_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_m0_gnt", 64'(m0_gnt_o), 64'(1));
        checkOutput("rst_m1_gnt", 64'(m1_gnt_o), 64'(1));
        checkOutput("rst_mem_req", 64'(mem_req_o), 64'(0));
        checkOutput("rst_rvalids", 64'({m0_rvalid_o, m1_rvalid_o}), 64'(0));
        checkOutput("rst_m0_rdata", 64'(m0_rdata_o), 64'(0));
        checkOutput("rst_mem_fields", 64'({mem_addr_o, mem_we_o, mem_be_o}), 64'(0));
        reset = 1'b0;
        tick();

        // Single read, zero-wait memory: response 4 cycles after the request
        applyStimulus(0, 32'h0000_0040, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 4, 1'b1, 1'b1);
        tick();
        waitIdle(50);

        // Simultaneous requests: port 0 wins the first tie, port 1 waits one transaction
        applyStimulus(0, 32'h0000_0100, 32'h0, 1'b0, 4'hF, 32'h1111_0000, 1'b0, 4, 1'b1, 1'b1);
        applyStimulus(1, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 4'b0011, 32'h0, 1'b0, 8, 1'b1, 1'b1);
        tick();
        waitIdle(50);

        // Next tie goes to port 1; its write returns a bus error
        applyStimulus(1, 32'h0000_0204, 32'h5A5A_5A5A, 1'b1, 4'b1100, 32'hFFFF_0000, 1'b1, 4, 1'b1, 1'b1);
        applyStimulus(0, 32'h0000_0104, 32'h0, 1'b0, 4'hF, 32'h2222_0000, 1'b0, 8, 1'b1, 1'b1);
        tick();
        waitIdle(50);

        // Memory stalls the grant for 5 cycles
        mem_gnt_wait = 5;
        applyStimulus(0, 32'h0000_0300, 32'h0, 1'b0, 4'hF, 32'h1234_5678, 1'b0, 9, 1'b1, 1'b1);
        tick();
        waitIdle(60);
        mem_gnt_wait = 0;

        // Back-to-back: new request issued during the RESP cycle
        applyStimulus(0, 32'h0000_0500, 32'h0, 1'b0, 4'hF, 32'hCAFE_0001, 1'b0, 4, 1'b1, 1'b1);
        tick();
        n = 0;
        while (!m0_rvalid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_resp_seen", 64'(m0_rvalid_o), 64'(1));
        checkOutput("b2b_gnt_in_resp", 64'(m0_gnt_o), 64'(1));
        applyStimulus(0, 32'h0000_0504, 32'h0000_0077, 1'b1, 4'hF, 32'hCAFE_0002, 1'b0, 4, 1'b1, 1'b1);
        tick();
        waitIdle(50);

        // Timeout: granted but never answered, error 8 cycles into WAIT_RESP
        mem_silent = 1'b1;
        applyStimulus(1, 32'h0000_0400, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 11, 1'b0, 1'b1);
        tick();
        waitIdle(60);

        // Reset while waiting for a response, then a late response arrives
        applyStimulus(0, 32'h0000_0600, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_m0_gnt", 64'(m0_gnt_o), 64'(0));
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_gnts", 64'({m0_gnt_o, m1_gnt_o}), 64'(2'b11));
        checkOutput("mid_rst_mem_req", 64'(mem_req_o), 64'(0));
        checkOutput("mid_rst_rvalids", 64'({m0_rvalid_o, m1_rvalid_o}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_silent = 1'b0;
        inject_late = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("late_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'(0));
            checkOutput("late_mem_req", 64'(mem_req_o), 64'(0));
        end

        // Normal operation resumes after reset
        applyStimulus(1, 32'h0000_0700, 32'h0, 1'b0, 4'hF, 32'h0F0F_0F0F, 1'b0, 4, 1'b1, 1'b1);
        tick();
        waitIdle(50);

        checkOutput("model_queue_empty", 64'(model_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the two per-core caches (instruction and data) and merges their memory-side request ports onto the single memory bus port.
- Each upstream port captures a one-cycle request pulse into a one-entry buffer.
- Requests are arbitrated round-robin, with one memory transaction in flight at a time.
- Each response is routed back to its originating port; a stalled memory returns an error on timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, cycles waited in WAIT_RESP before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mN_addr_i (N=0,1)  in  ADDR_W  request address.
- mN_wdata_i  in  DATA_W  write data.
- mN_we_i  in  1  1 = write.
- mN_be_i  in  DATA_W/8  byte enables.
- mN_req_i  in  1  request pulse; sampled only when mN_gnt_o=1.
- mN_gnt_o  out  1  port buffer empty, request will be captured.
- mN_rdata_o  out  DATA_W  response data, registered.
- mN_rvalid_o  out  1  one-cycle response strobe, registered.
- mN_error_o  out  1  qualifies mN_rvalid_o; 1 = bus error or timeout.
- mem_addr_o / mem_wdata_o / mem_we_o / mem_be_o  out  ADDR_W / DATA_W / 1 / DATA_W/8  selected request fields, registered.
- mem_req_o  out  1  held high until mem_gnt_i.
- mem_rdata_i  in  DATA_W  memory response data.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  memory response strobe, for both reads and writes.
- mem_error_i  in  1  qualifies mem_rvalid_i.

Behaviour:
- Reset values: all buffers invalid; mN_gnt_o=1; mN_rvalid_o=0; mN_error_o=0; mN_rdata_o=0; mem_req_o=0; all mem_* outputs 0; state IDLE; last_grant=1 (so port 0 wins the first tie); timeout counter 0.
- Capture:
  - mN_gnt_o = ~bufN_valid (combinational).
  - At a clock edge with mN_req_i & mN_gnt_o, store {addr, wdata, we, be} and set bufN_valid.
  - mN_req_i while the buffer is full is ignored; no capture and no error.
- State IDLE:
  - If either buffer is valid, select a port; drive mem_* from that buffer and set mem_req_o=1 at the next edge; go to ISSUE.
  - If both are valid, select the port != last_grant; update last_grant to the selected port.
- State ISSUE:
  - Hold mem_req_o and all fields stable.
  - On mem_gnt_i: drop mem_req_o; go to WAIT_RESP; clear the timeout counter.
  - If mem_rvalid_i coincides with mem_gnt_i, treat it as the response and go straight to RESP.
- State WAIT_RESP:
  - Counter increments each cycle.
  - On mem_rvalid_i: latch rdata and error, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: latch rdata=0 and error=1, go to RESP.
- State RESP (one cycle):
  - Selected port: mN_rvalid_o=1 and mN_error_o as latched; mN_rdata_o holds the latched value until the next response to that port.
  - Selected buffer is cleared at the edge entering RESP, so its mN_gnt_o=1 during RESP; a new request in that cycle is captured.
  - Return to IDLE.
  - The other port's outputs are unchanged; its rvalid stays 0.
- mem_rvalid_i outside WAIT_RESP, or outside the gnt cycle of ISSUE, is ignored.
- Latency with zero-wait memory (gnt in the first ISSUE cycle, rvalid the next cycle):
  - req at c0, buffer valid c1, mem_req_o c2, mem_rvalid_i c3, mN_rvalid_o c4.
  - Total: 4 cycles.
- Simultaneous requests: both are captured in the same edge; served in round-robin order; the loser waits one full transaction.
- Reset mid-operation: mem_req_o and all strobes drop asynchronously, buffers are discarded, and a late memory response after reset is ignored.
- Width rules: the timeout counter is $clog2(TIMEOUT+1) bits, minimum 1; fields pass through unmodified with no byte realignment.

Decomposition:
- Package mem_bus_pkg holds:
  - state localparams IDLE=2'd0, ISSUE=2'd1, WAIT_RESP=2'd2, RESP=2'd3;
  - request-buffer field offsets (we, be, wdata, addr);
  - the port index constants.
- Sub-module mem_req_buffer: the one-entry capture buffer with inputs req/fields/clear and outputs valid/fields/gnt. It is instantiated twice.

Test Plan:
- Single read: m0 read at 0x0000_0040; memory gnt immediately, rvalid next cycle with 0xDEADBEEF -> m0_rvalid_o 4 cycles after req, m0_rdata_o=0xDEADBEEF, m0_error_o=0, m1 outputs idle.
- Simultaneous: m0 read 0x100 and m1 write 0x200 (wdata 0xA5A5A5A5, be 4'b0011) in the same cycle -> mem sees 0x100 first, then 0x200 with we=1 and be=0011; next tie goes to m1.
- Memory stall: mem_gnt_i low for 5 cycles -> mem_req_o and all fields held stable for 5 cycles; response delivered after gnt.
- Timeout: TIMEOUT=8, memory grants but never responds -> mN_rvalid_o=1 with error=1 and rdata=0, 8 cycles after entering WAIT_RESP; arbiter back in IDLE.
- Back-to-back: m0 issues a new req in its RESP cycle -> captured (gnt=1) and issued next.
- Reset mid-WAIT_RESP: assert reset, then send a late mem_rvalid_i -> no mN_rvalid_o, gnt=1 on both ports, mem_req_o=0.
